// File: rtl/cmp_iter.sv
// Multi-cycle add/compare: processes CHUNK bits per cycle LSB first with a rippled carry,
// returning result, {N,Z,C,V} and signed/unsigned less-than over valid/ready handshakes.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one chunk of A + B' + carry per cycle
// DONE  | out_valid high, outputs held until out_ready
module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag,
  output logic             lt_s,
  output logic             lt_u
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              s_q, carry_q, zacc_q;
  logic [CW-1:0]     cnt_q;

  int                shamt;
  logic [CHUNK-1:0]  a_i, b_i, r;
  logic [CHUNK:0]    sum;
  logic              c_out, n_bit, z_bit, v_bit;
  logic [WIDTH-1:0]  chunk_mask, r_ext;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    shamt      = CHUNK * int'(cnt_q);
    a_i        = CHUNK'(a_q >> shamt);
    b_i        = CHUNK'(b_q >> shamt);
    sum        = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_q};
    r          = sum[CHUNK-1:0];
    c_out      = sum[CHUNK];
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    r_ext      = WIDTH'(r) << shamt;
    n_bit      = r[CHUNK-1];
    z_bit      = zacc_q & (r == '0);
    // B' already holds ~In2 for subtract, so V compares against the inverted operand
    v_bit      = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (r[CHUNK-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= 1'b0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b1;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= 4'b0000;
      lt_s      <= 1'b0;
      lt_u      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= In1;
            b_q     <= S ? ~In2 : In2;
            s_q     <= S;
            carry_q <= S;
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          result  <= (result & ~chunk_mask) | r_ext;
          carry_q <= c_out;
          zacc_q  <= zacc_q & (r == '0);
          if (cnt_q == LAST) begin
            flag      <= {n_bit, z_bit, c_out, v_bit};
            lt_s      <= s_q & (n_bit ^ v_bit);
            lt_u      <= s_q & ~c_out;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter: 32/8 instance for arithmetic, handshake and reset cases,
// plus a 16/16 instance for the single-chunk latency case.
module tb_cmp_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, S, out_ready;
  logic [31:0] In1, In2;
  logic        in_ready, out_valid, lt_s, lt_u;
  logic [31:0] result;
  logic [3:0]  flag;

  logic        in_valid16, S16, out_ready16;
  logic [15:0] In1_16, In2_16;
  logic        in_ready16, out_valid16, lt_s16, lt_u16;
  logic [15:0] result16;
  logic [3:0]  flag16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .In1(In1), .In2(In2), .S(S), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .lt_s(lt_s), .lt_u(lt_u)
  );

  cmp_iter #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .In1(In1_16), .In2(In2_16), .S(S16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .flag(flag16), .lt_s(lt_s16), .lt_u(lt_u16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Accept one operation on the 32-bit unit and return the cycles until out_valid.
  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    in_valid = 1'b1; S = s; In1 = a; In2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic [3:0] exp_f,
                      input logic exp_ls, input logic exp_lu);
    int lat;
    issue32(s, a, b, lat);
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".flag"}, 32'(flag), 32'(exp_f));
    chk({tag, ".lt_s"}, 32'(lt_s), 32'(exp_ls));
    chk({tag, ".lt_u"}, 32'(lt_u), 32'(exp_lu));
    @(posedge clk); #1;
    chk({tag, ".drain"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; S = 1'b0; out_ready = 1'b1; In1 = '0; In2 = '0;
    in_valid16 = 1'b0; S16 = 1'b0; out_ready16 = 1'b1; In1_16 = '0; In2_16 = '0;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.flag_lt", 32'({flag, lt_s, lt_u}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    op32("negsub", 1'b1, 32'd10,         32'hFFFF_FFF1, 32'd25,         4'b0000, 1'b0, 1'b1);
    op32("equal",  1'b1, 32'd5,          32'd5,         32'd0,          4'b0110, 1'b0, 1'b0);
    op32("addc",   1'b0, 32'd7,          32'hFFFF_FFFE, 32'd5,          4'b0010, 1'b0, 1'b0);
    op32("ovfsub", 1'b1, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  4'b0011, 1'b1, 1'b0);
    op32("ovfadd", 1'b0, 32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  4'b1001, 1'b0, 1'b0);
    op32("borrow", 1'b1, 32'd3,          32'd9,         32'hFFFF_FFFA,  4'b1000, 1'b1, 1'b1);

    // Backpressure: result held while out_ready low, new requests ignored
    out_ready = 1'b0;
    issue32(1'b0, 32'h1234_5678, 32'h1111_1111, lat);
    chk("bp.lat", 32'(lat), 32'd4);
    chk("bp.result", result, 32'h2345_6789);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; S = 1'b1; In1 = 32'hFFFF_FFFF; In2 = 32'd1;
      @(posedge clk); #1;
      chk("bp.hold_result", result, 32'h2345_6789);
      chk("bp.hold_flag", 32'(flag), 32'd0);
      chk("bp.hold_hs", 32'({in_ready, out_valid}), 32'b01);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release", 32'({in_ready, out_valid}), 32'b10);
    repeat (6) @(posedge clk);
    #1 chk("bp.no_ghost", 32'(out_valid), 32'd0);

    // Reset during RUN aborts the operation
    @(negedge clk);
    in_valid = 1'b1; S = 1'b0; In1 = 32'd1; In2 = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.flag", 32'(flag), 32'd0);
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("abort.no_valid", 32'(out_valid), 32'd0);

    // Single-chunk configuration: one RUN cycle
    @(negedge clk);
    in_valid16 = 1'b1; S16 = 1'b1; In1_16 = 16'd5; In2_16 = 16'd5;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16.lat", 32'(lat), 32'd1);
    chk("w16.result", 32'(result16), 32'd0);
    chk("w16.flag", 32'(flag16), 32'b0110);
    chk("w16.lt", 32'({lt_s16, lt_u16}), 32'b00);
    @(posedge clk); #1;
    chk("w16.drain", 32'({in_ready16, out_valid16}), 32'b10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
